// File: rtl/frost32_mem_bridge_pkg.sv
// Shared types for the Frost32 memory bridge.
//   DataInoutAccessType : CPU access direction (read / write)
//   DataInoutAccessSize : CPU access width (32 / 16 / 8 bit, or an illegal encoding)
//   MemBridgeState      : bridge sequencing state
//   MB_CNT_W            : width of the RAM read-latency down-counter
package frost32_mem_bridge_pkg;

   typedef enum logic {
      DiatRead  = 1'b0,
      DiatWrite = 1'b1
   } DataInoutAccessType;

   typedef enum logic [1:0] {
      Dias32  = 2'd0,
      Dias16  = 2'd1,
      Dias8   = 2'd2,
      DiasBad = 2'd3
   } DataInoutAccessSize;

   typedef enum logic [1:0] {
      StMbIdle,
      StMbIssue,
      StMbWait,
      StMbDone
   } MemBridgeState;

   // Enough for read latencies of 1..15 cycles.
   localparam int MB_CNT_W = 4;

endpackage

// File: rtl/frost32_mem_lane_unit.sv
// Combinational byte-lane steering for the Frost32 memory bridge.
//   addr_lo    : byte offset within the 32-bit word
//   size       : access size (DataInoutAccessSize encoding)
//   data_in    : right-aligned CPU write data
//   ram_rdata  : raw RAM word
//   byte_en    : byte lane enables for the access
//   wdata      : write data replicated onto every lane
//   rd_value   : selected lane(s) right-aligned and zero-extended
//   misaligned : address not naturally aligned for the size
// An illegal size yields all-zero outputs; the caller rejects it separately.
module frost32_mem_lane_unit
   import frost32_mem_bridge_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic [31:0] data_in,
   input  logic [31:0] ram_rdata,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata,
   output logic [31:0] rd_value,
   output logic        misaligned
);

   logic [31:0] shifted;

   always_comb begin
      byte_en    = '0;
      wdata      = '0;
      rd_value   = '0;
      misaligned = 1'b0;
      // Bring the addressed lane down to bit 0 for sub-word reads.
      shifted    = ram_rdata >> {addr_lo, 3'b000};
      case (DataInoutAccessSize'(size))
         Dias32: begin
            byte_en    = 4'b1111;
            wdata      = data_in;
            rd_value   = ram_rdata;
            misaligned = |addr_lo;
         end
         Dias16: begin
            byte_en    = 4'b0011 << addr_lo;
            wdata      = {2{data_in[15:0]}};
            rd_value   = {16'h0000, shifted[15:0]};
            misaligned = addr_lo[0];
         end
         Dias8: begin
            byte_en    = 4'b0001 << addr_lo;
            wdata      = {4{data_in[7:0]}};
            rd_value   = {24'h000000, shifted[7:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/frost32_mem_bridge.sv
// Bridge between the Frost32 CPU memory port and a word-wide synchronous RAM.
//   clk, rst               : clock, asynchronous active-high reset
//   req_mem_access         : CPU request strobe
//   data_inout_access_type : 0 read, 1 write
//   data_inout_access_size : Dias32 / Dias16 / Dias8 / DiasBad
//   addr, data_in          : byte address, right-aligned write data
//   data_out               : registered, right-aligned, zero-extended read data
//   wait_for_mem           : CPU stall
//   misaligned_err         : one-cycle pulse when an access is rejected
//   ram_*                  : RAM strobe, write enable, word address, lanes, data
// Sequence: IDLE -> ISSUE (one ram_en cycle) -> [WAIT for reads] -> DONE -> IDLE.
// Rejected accesses go IDLE -> DONE without touching the RAM.
module frost32_mem_bridge
   import frost32_mem_bridge_pkg::*;
#(
   parameter int RAM_ADDR_W  = 14,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_mem_access,
   input  logic                  data_inout_access_type,
   input  logic [1:0]            data_inout_access_size,
   input  logic [31:0]           addr,
   input  logic [31:0]           data_in,
   output logic [31:0]           data_out,
   output logic                  wait_for_mem,
   output logic                  misaligned_err,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [3:0]            ram_byte_en,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata
);

   MemBridgeState         state_q, state_d;
   logic                  write_q, write_d;
   logic                  err_q, err_d;
   logic [1:0]            addr_lo_q, addr_lo_d;
   logic [1:0]            size_q, size_d;
   logic [MB_CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]           data_out_q, data_out_d;
   logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [3:0]            ram_byte_en_q, ram_byte_en_d;
   logic [31:0]           ram_wdata_q, ram_wdata_d;

   // The lane unit sees the live request while idle and the latched access
   // otherwise, so one instance serves both request decode and read extraction.
   logic        is_idle;
   logic [1:0]  lane_addr_lo;
   logic [1:0]  lane_size;
   logic [3:0]  lane_byte_en;
   logic [31:0] lane_wdata;
   logic [31:0] lane_rd;
   logic        lane_mis;
   logic        reject;

   assign is_idle      = (state_q == StMbIdle);
   assign lane_addr_lo = is_idle ? addr[1:0] : addr_lo_q;
   assign lane_size    = is_idle ? data_inout_access_size : size_q;
   assign reject       = lane_mis | (lane_size == DiasBad);

   frost32_mem_lane_unit u_lane (
      .addr_lo    (lane_addr_lo),
      .size       (lane_size),
      .data_in    (data_in),
      .ram_rdata  (ram_rdata),
      .byte_en    (lane_byte_en),
      .wdata      (lane_wdata),
      .rd_value   (lane_rd),
      .misaligned (lane_mis)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StMbIdle;
         write_q       <= 1'b0;
         err_q         <= 1'b0;
         addr_lo_q     <= '0;
         size_q        <= '0;
         cnt_q         <= '0;
         data_out_q    <= '0;
         ram_addr_q    <= '0;
         ram_byte_en_q <= '0;
         ram_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         write_q       <= write_d;
         err_q         <= err_d;
         addr_lo_q     <= addr_lo_d;
         size_q        <= size_d;
         cnt_q         <= cnt_d;
         data_out_q    <= data_out_d;
         ram_addr_q    <= ram_addr_d;
         ram_byte_en_q <= ram_byte_en_d;
         ram_wdata_q   <= ram_wdata_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      err_d         = err_q;
      addr_lo_d     = addr_lo_q;
      size_d        = size_q;
      cnt_d         = cnt_q;
      data_out_d    = data_out_q;
      ram_addr_d    = ram_addr_q;
      ram_byte_en_d = ram_byte_en_q;
      ram_wdata_d   = ram_wdata_q;
      case (state_q)
         StMbIdle: begin
            if (req_mem_access) begin
               write_d   = data_inout_access_type;
               addr_lo_d = addr[1:0];
               size_d    = data_inout_access_size;
               err_d     = reject;
               if (reject) begin
                  data_out_d = '0;
                  state_d    = StMbDone;
               end else begin
                  // RAM-side outputs only move for accesses that reach the RAM.
                  ram_addr_d    = addr[RAM_ADDR_W+1:2];
                  ram_byte_en_d = lane_byte_en;
                  ram_wdata_d   = lane_wdata;
                  state_d       = StMbIssue;
               end
            end
         end
         StMbIssue: begin
            if (write_q) begin
               state_d = StMbDone;
            end else begin
               cnt_d   = MB_CNT_W'(MEM_LATENCY - 1);
               state_d = StMbWait;
            end
         end
         StMbWait: begin
            if (cnt_q == '0) begin
               data_out_d = lane_rd;
               state_d    = StMbDone;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StMbIdle;
      endcase
   end

   always_comb begin
      ram_en         = (state_q == StMbIssue);
      ram_we         = (state_q == StMbIssue) & write_q;
      misaligned_err = (state_q == StMbDone) & err_q;
      // Combinational so the CPU stalls in the request cycle itself.
      wait_for_mem   = ~rst & ((is_idle & req_mem_access) |
                               (state_q == StMbIssue) | (state_q == StMbWait));
   end

   assign data_out    = data_out_q;
   assign ram_addr    = ram_addr_q;
   assign ram_byte_en = ram_byte_en_q;
   assign ram_wdata   = ram_wdata_q;

endmodule

// File: doc/frost32_mem_bridge.md
Name: frost32_mem_bridge

Overview:
- Sits directly downstream of the Frost32 CPU memory-access port.
- Consumes the CPU's request fields (address, write data, access type, access size, request strobe). Drives a word-wide synchronous RAM with a fixed read latency.
- Returns read data and the wait_for_mem stall signal that feed the CPU's input port.
- Handles sub-word byte lanes, alignment checking and wait-state sequencing.

Parameters:
- RAM_ADDR_W, 14, word-address width of the RAM (2^14 words = 64 KiB).
- MEM_LATENCY, 1, RAM read latency in cycles from ram_en to valid ram_rdata. Legal range is 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_mem_access  in  1  CPU request strobe
- data_inout_access_type  in  1  0 = DiatRead, 1 = DiatWrite
- data_inout_access_size  in  2  Dias32 = 0, Dias16 = 1, Dias8 = 2, DiasBad = 3
- addr  in  32  byte address
- data_in  in  32  write data, right-aligned
- data_out  out  32  read data, right-aligned and zero-extended; registered
- wait_for_mem  out  1  CPU stall request
- misaligned_err  out  1  one-cycle error pulse
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  RAM_ADDR_W  word address, equal to addr[RAM_ADDR_W+1:2]
- ram_byte_en  out  4  byte lane enables
- ram_wdata  out  32  lane-positioned write data
- ram_rdata  in  32  RAM read data

Behaviour:
- **Reset.** While rst is high:
  - state = IDLE.
  - data_out, ram_addr, ram_wdata and ram_byte_en = 0.
  - ram_en, ram_we and misaligned_err = 0.
  - wait_for_mem is forced to 0.
  - Reset asserted mid-operation abandons the access; no write is completed afterwards.
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE.**
  - On req_mem_access = 1, latch addr, data_in, type and size; go to ISSUE.
  - If the access is misaligned or DiasBad, go to DONE instead.
  - Misaligned means Dias32 with addr[1:0] != 0, or Dias16 with addr[0] != 0.
- **ISSUE.**
  - ram_en = 1 for exactly one cycle, with ram_addr and ram_byte_en valid.
  - ram_we = 1 for writes only.
  - A write goes next to DONE; a read goes next to WAIT with the counter set to MEM_LATENCY - 1.
- **WAIT.**
  - Counter decrements each cycle.
  - When the counter is 0, ram_rdata is valid: latch the extracted lane into data_out and go to DONE.
- **DONE.**
  - wait_for_mem = 0 and data_out is valid.
  - misaligned_err = 1 if the access was rejected.
  - Next state is always IDLE.
- **wait_for_mem.** Combinational: (IDLE & req_mem_access) | ISSUE | WAIT.
  - It therefore rises in the same cycle as the request.
- **Handshake rules.**
  - The CPU holds its request fields stable while wait_for_mem = 1.
  - The CPU deasserts req_mem_access in the cycle after DONE, or presents a new request there. A request present in IDLE is always treated as a new request.
  - Changes to request inputs outside IDLE are ignored.
- **Latency.** Counted from the request cycle (cycle 0) to the DONE cycle:
  - Write: DONE at cycle 2.
  - Read: DONE at cycle 2 + MEM_LATENCY.
  - Rejected access: DONE at cycle 1, with no ram_en, data_out = 0 and misaligned_err = 1.
- **Lanes.** Little-endian; lane k = bits 8k+7:8k.
  - Dias8: byte_en = 1 << addr[1:0]; wdata = data_in[7:0] replicated to all 4 lanes; read data is zero-extended.
  - Dias16: byte_en = 4'b0011 << addr[1:0]; wdata = data_in[15:0] replicated; read data is zero-extended.
  - Dias32: byte_en = 4'b1111.
- **Reads.** ram_byte_en is driven with the same pattern as writes, for information only.
- **Address range.** addr bits above RAM_ADDR_W+1 are ignored, so addresses wrap modulo RAM size. There is no out-of-range error.
- **Idle outputs.** Outside ISSUE, ram_en = 0 and ram_we = 0; the other RAM outputs hold their last values.
- **data_out** holds its value until the next completed read or rejected access.

Decomposition:
- **PkgFrost32Cpu:**
  - Add typedef enum MemBridgeState {StMbIdle, StMbIssue, StMbWait, StMbDone}.
  - Reuse DataInoutAccessType and DataInoutAccessSize.
  - Add a define for the MEM_LATENCY counter width (4 bits).
- **Sub-module frost32_mem_lane_unit:** combinational.
  - From (addr[1:0], size, data_in, ram_rdata) it produces byte_en, wdata, the extracted read value and the misaligned flag.
  - It is shared by the write and read paths and unit-testable on its own.

Test Plan:
- **Dias32 write, then read** (MEM_LATENCY = 1): write addr 0x0000_0010, data_in 0xDEADBEEF.
  - Write: ram_en/ram_we at cycle 1, ram_addr 4, byte_en 4'hF; wait_for_mem = 1 for cycles 0–1 and 0 at cycle 2.
  - Read of the same address: DONE at cycle 3 with data_out 0xDEADBEEF.
- **Dias8 write** to addr 0x13 with data_in 0x0000_00A5: byte_en 4'b1000, wdata 0xA5A5A5A5.
  - A subsequent Dias8 read of 0x13, with RAM word 0xA5EFBEEF, gives data_out 0x0000_00A5.
- **Dias16 read** at addr 0x12 with RAM word 0x1234_5678: byte_en 4'b1100, data_out 0x0000_1234.
- **Misaligned Dias32 at addr 0x0000_0002:** no ram_en ever; DONE at cycle 1 with misaligned_err = 1 for one cycle and data_out = 0. DiasBad gives the same response.
- **MEM_LATENCY = 3 read:** wait_for_mem high for cycles 0–4 and low at cycle 5; data captured only when the counter reaches 0.
- **Reset mid-read:** assert rst in the WAIT cycle → immediately IDLE, wait_for_mem 0, ram_en 0, data_out 0. After release, a new request completes normally.
